// File: rtl/bist_pkg.sv
// bist_pkg: shared definitions for the BIST vector engine.
//   - FSM state encodings (IDLE, RUN, DRAIN, DONE)
//   - default width constants for the engine parameters
//   - clog2 helper used to size address fields

package bist_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Default parameter values
    localparam int unsigned DEF_DEPTH  = 256;
    localparam int unsigned DEF_STIM_W = 5;
    localparam int unsigned DEF_RESP_W = 4;
    localparam int unsigned DEF_LOOP_W = 8;
    localparam int unsigned DEF_CNT_W  = 16;

    // Ceiling log2, never below 1 so address fields always have a bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bist_vec_ram.sv
// bist_vec_ram: vector storage for the BIST engine.
// One synchronous write port, one asynchronous read port. Contents are not reset.
// Ports:
//   clk    - write clock, rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data, combinational from raddr

module bist_vec_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 14,
    parameter int unsigned AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bist_vector_engine.sv
// bist_vector_engine: BIST vector player.
// Vectors {stim, exp, mask, last} are loaded through the load_* port, then replayed
// to the DUT on start. Each response is compared one cycle after its stimulus under a
// per-bit mask; the engine keeps a saturating mismatch count and captures the address
// and response of the first mismatch. Optional multi-pass looping and abort.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   load_clr                    - clear write pointer and vector count
//   load_en, load_stim/exp/mask/last - write one vector (ignored while busy)
//   load_full                   - DEPTH vectors stored
//   start, abort                - begin run (IDLE/DONE only) / stop run
//   loop_en, loop_cnt           - multi-pass control, sampled at start
//   stim_out, stim_valid        - stimulus to DUT
//   resp_in                     - DUT response
//   busy, done, pass            - status
//   fail_count                  - saturating mismatch count
//   first_fail_addr/resp        - first mismatch capture

module bist_vector_engine
    import bist_pkg::*;
#(
    parameter  int unsigned DEPTH  = DEF_DEPTH,
    parameter  int unsigned STIM_W = DEF_STIM_W,
    parameter  int unsigned RESP_W = DEF_RESP_W,
    parameter  int unsigned LOOP_W = DEF_LOOP_W,
    parameter  int unsigned CNT_W  = DEF_CNT_W,
    localparam int unsigned AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_clr,
    input  logic              load_en,
    input  logic [STIM_W-1:0] load_stim,
    input  logic [RESP_W-1:0] load_exp,
    input  logic [RESP_W-1:0] load_mask,
    input  logic              load_last,
    output logic              load_full,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    input  logic [LOOP_W-1:0] loop_cnt,
    output logic [STIM_W-1:0] stim_out,
    output logic              stim_valid,
    input  logic [RESP_W-1:0] resp_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  fail_count,
    output logic [AW-1:0]     first_fail_addr,
    output logic [RESP_W-1:0] first_fail_resp
);

    localparam int unsigned ENTRY_W = STIM_W + 2 * RESP_W + 1;
    localparam logic [AW:0] NVEC_FULL = (AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [LOOP_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [AW:0]       nvec_q;

    // Compare pipeline: expectation of the vector presented last cycle
    logic              cmp_valid_q;
    logic [RESP_W-1:0] cmp_exp_q;
    logic [RESP_W-1:0] cmp_mask_q;
    logic [AW-1:0]     cmp_addr_q;

    logic [CNT_W-1:0]  fail_count_q;
    logic              first_seen_q;
    logic [AW-1:0]     first_fail_addr_q;
    logic [RESP_W-1:0] first_fail_resp_q;

    // ------------------------------------------------------------------
    // Vector memory
    // ------------------------------------------------------------------
    logic [AW-1:0]      wptr;
    logic               wr_en;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic [STIM_W-1:0]  rd_stim;
    logic [RESP_W-1:0]  rd_exp;
    logic [RESP_W-1:0]  rd_mask;
    logic               rd_last;

    // The write pointer always equals the vector count below DEPTH.
    assign wptr      = nvec_q[AW-1:0];
    assign load_full = (nvec_q == NVEC_FULL);
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign wr_en     = load_en && !load_clr && !busy && !load_full;
    assign wr_entry  = {load_stim, load_exp, load_mask, load_last};

    bist_vec_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr),
        .wdata (wr_entry),
        .raddr (addr_q),
        .rdata (rd_entry)
    );

    assign rd_last = rd_entry[0];
    assign rd_mask = rd_entry[RESP_W:1];
    assign rd_exp  = rd_entry[2*RESP_W:RESP_W+1];
    assign rd_stim = rd_entry[ENTRY_W-1:2*RESP_W+1];

    // Vector count. Clearing is held off during a run because the count bounds
    // the replay; a mid-run clear would leave the end vector undefined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nvec_q <= '0;
        end else if (load_clr && !busy) begin
            nvec_q <= '0;
        end else if (wr_en) begin
            nvec_q <= nvec_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic end_vec;
    logic run_start;

    assign end_vec = rd_last || ({1'b0, addr_q} == nvec_q - 1'b1);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pass_cnt_d = pass_cnt_q;
        run_start  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                // abort wins over start in the same cycle
                if (start && !abort) begin
                    run_start  = 1'b1;
                    addr_d     = '0;
                    pass_cnt_d = loop_en ? loop_cnt : '0;
                    state_d    = (nvec_q != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (end_vec) begin
                    if (pass_cnt_q != '0) begin
                        // wrap straight back to vector 0, no idle cycle between passes
                        addr_d     = '0;
                        pass_cnt_d = pass_cnt_q - 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = abort ? IDLE : DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            pass_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Response compare
    // ------------------------------------------------------------------
    logic mismatch;

    assign mismatch = cmp_valid_q && (|((resp_in ^ cmp_exp_q) & cmp_mask_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_mask_q  <= '0;
            cmp_addr_q  <= '0;
        end else begin
            // A vector presented in an abort cycle is never compared.
            cmp_valid_q <= (state_q == RUN) && !abort;
            cmp_exp_q   <= rd_exp;
            cmp_mask_q  <= rd_mask;
            cmp_addr_q  <= addr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_count_q      <= '0;
            first_seen_q      <= 1'b0;
            first_fail_addr_q <= '0;
            first_fail_resp_q <= '0;
        end else if (run_start) begin
            fail_count_q      <= '0;
            first_seen_q      <= 1'b0;
            first_fail_addr_q <= '0;
            first_fail_resp_q <= '0;
        end else if (mismatch) begin
            if (fail_count_q != '1) begin
                fail_count_q <= fail_count_q + 1'b1;
            end
            if (!first_seen_q) begin
                first_seen_q      <= 1'b1;
                first_fail_addr_q <= cmp_addr_q;
                first_fail_resp_q <= resp_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stim_valid      = (state_q == RUN);
    assign stim_out        = stim_valid ? rd_stim : '0;
    assign done            = (state_q == DONE);
    assign pass            = done && (fail_count_q == '0);
    assign fail_count      = fail_count_q;
    assign first_fail_addr = first_fail_addr_q;
    assign first_fail_resp = first_fail_resp_q;

endmodule
